// File: rtl/serial_rx.sv
// serial_rx: UART receiver, 8N1, LSB first, idle-high line.
// Turns the asynchronous serialIn line into parallel bytes. The
// receive-side counterpart of the cereal transmitter.
//
// Ports:
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   serialIn   in   asynchronous UART line, idle high
//   data       out  [7:0] last good byte received
//   valid      out  one-cycle strobe, data updated with a good frame
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   is_bs      out  with valid: byte is 0x08 or 0x7F, otherwise 0
//   busy       out  high in any state other than IDLE
//
// Build option:
//   SERIAL_RX_MAJORITY_EN  each start/data/stop sample is a 2-of-3 vote over
//                          the three cycles ending at the nominal point.
//                          Undefined: single sample at the nominal point.
//
// state | meaning
// IDLE  | waiting for the line to fall
// START | counting to mid start bit to validate it
// DATA  | sampling 8 data bits at mid-bit
// STOP  | counting to mid stop bit, then strobe valid or frame_err
module serial_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF         = CLKS_PER_BIT / 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       is_bs,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_sh;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_is_bs;
  logic            r_sync1;
  logic            r_sync2;

  state_t          w_state;
  logic [CW-1:0]   w_cnt;
  logic [2:0]      w_idx;
  logic [7:0]      w_sh;
  logic [7:0]      w_data;
  logic            w_valid;
  logic            w_ferr;
  logic            w_is_bs;
  logic            w_rx;
  logic            w_bit;

  assign w_rx = r_sync2;

`ifdef SERIAL_RX_MAJORITY_EN
  // Two previous synchronized samples; with w_rx they form the three votes
  // ending at the nominal sample point.
  logic [1:0] r_hist;

  always_ff @(posedge sysclk) begin
    if (reset) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], w_rx};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`else
  assign w_bit = w_rx;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_is_bs <= 1'b0;
    end else begin
      r_sync1 <= serialIn;
      r_sync2 <= r_sync1;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_sh    <= w_sh;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      r_is_bs <= w_is_bs;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_sh    = r_sh;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    w_is_bs = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state = S_START;
          w_cnt   = '0;
        end
      end

      S_START: begin
        if (r_cnt == HALF_END) begin
          if (w_bit) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_DATA;
            w_cnt   = '0;
            w_idx   = '0;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (r_cnt == BIT_END) begin
          w_sh  = {w_bit, r_sh[7:1]};
          w_cnt = '0;
          w_idx = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state = S_STOP;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_STOP: begin
        // Back to IDLE at mid-stop so a start bit right after the stop bit
        // is caught.
        if (r_cnt == BIT_END) begin
          w_state = S_IDLE;
          if (w_bit) begin
            w_data  = r_sh;
            w_valid = 1'b1;
            w_is_bs = (r_sh == 8'h08) || (r_sh == 8'h7F);
          end else begin
            w_ferr = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign is_bs     = r_is_bs;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx. Uses a short bit period so
// all frames fit in a small cycle budget. Stimulus pushes the expected strobe
// (kind, data, is_bs, arrival cycle); a monitor pops on every strobe.
module tb_serial_rx;

  localparam int CPB  = 64;
  localparam int HALF = CPB / 2;
  localparam int LAT  = HALF + 9 * CPB + 3;

  logic       sysclk   = 1'b0;
  logic       reset    = 1'b1;
  logic       serialIn = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       is_bs;
  logic       busy;

  serial_rx #(.CLKS_PER_BIT(CPB), .HALF(HALF)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .serialIn (serialIn),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .is_bs    (is_bs),
    .busy     (busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc++;

  typedef struct {
    bit         err;
    logic [7:0] d;
    bit         bs;
    int         t;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_is_bs"}, is_bs, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic push(input bit err, input logic [7:0] d, input bit bs);
    exp_t e;
    e.err = err;
    e.d   = d;
    e.bs  = bs;
    e.t   = cyc + LAT;
    q.push_back(e);
  endtask

  // glitch_bit: data bit pulled low for one cycle at its mid-bit sample.
  // rst_bit: data bit during which reset pulses and the frame is abandoned.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int glitch_bit, input int rst_bit);
    serialIn = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      if (i == rst_bit) begin
        repeat (CPB / 2) tick();
        serialIn = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midframe_reset");
        return;
      end
      if (i == glitch_bit) begin
        repeat (HALF) tick();
        serialIn = 1'b0;
        tick();
        serialIn = b[i];
        repeat (CPB - HALF - 1) tick();
      end else begin
        repeat (CPB) tick();
      end
    end
    serialIn = stop_v;
    repeat (CPB) tick();
    serialIn = 1'b1;
  endtask

  always @(negedge sysclk) begin
    if (valid || frame_err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe valid=%0b frame_err=%0b data=%0h required no strobe",
                 valid, frame_err, data);
      end else begin
        exp_t e;
        int   diff;
        e = q.pop_front();
        chk("strobe_frame_err", frame_err, e.err);
        chk("strobe_valid", valid, !e.err);
        chk("strobe_data", data, e.d);
        chk("strobe_is_bs", is_bs, e.bs);
        diff = cyc - e.t;
        checks++;
        if (diff < -2 || diff > 2) begin
          errors++;
          $display("FAIL strobe_latency actual_cycle=%0d required_cycle=%0d", cyc, e.t);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");
    repeat (5) tick();

    push(1'b0, 8'h41, 1'b0);
    send_frame(8'h41, 1'b1, -1, -1);
    repeat (10) tick();

    push(1'b0, 8'h08, 1'b1);
    send_frame(8'h08, 1'b1, -1, -1);
    push(1'b0, 8'h7F, 1'b1);
    send_frame(8'h7F, 1'b1, -1, -1);
    repeat (10) tick();

    serialIn = 1'b0;
    repeat (20) tick();
    serialIn = 1'b1;
    chk("false_start_busy_high", busy, 1'b1);
    repeat (HALF) tick();
    chk("false_start_busy_low", busy, 1'b0);
    repeat (10) tick();

    push(1'b1, 8'h7F, 1'b0);
    send_frame(8'h55, 1'b0, -1, -1);
    repeat (2 * CPB) tick();

    send_frame(8'hA5, 1'b1, -1, 4);
    repeat (2 * CPB) tick();
    chk("after_abort_busy", busy, 1'b0);

    push(1'b0, 8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1, -1, -1);
    repeat (10) tick();

`ifdef SERIAL_RX_MAJORITY_EN
    push(1'b0, 8'hFF, 1'b0);
`else
    push(1'b0, 8'hFB, 1'b0);
`endif
    send_frame(8'hFF, 1'b1, 2, -1);
    repeat (2 * CPB) tick();

    chk("queue_drained", q.size(), 0);
    chk("final_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
